mem_access_ctrl: RTL and testbench

Parametrised, multi-cycle successor to the MEM-stage access logic. It accepts one load/store request per transaction from the EX/MEM register and serialises it into byte accesses on a byte-wide RAM port with configurable read latency. It reassembles load data little-endian, applies sign or zero extension and returns a registered writeback response. It adds an IO region with back-pressure and load flush, which the current MEM stage does not have.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_access_ctrl_if.sv | 41 ++++
 rtl/mem_access_ctrl_ld_ext.sv | 29 ++
 rtl/mem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the multi-cycle MEM-stage access controller.
package mem_access_pkg;

   // Request size encodings; 2'd3 is treated as a full data word.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Address bit that selects the IO region by default.
   localparam int IO_BIT_DEF = 17;

   // Writes to this register are discarded by the register file.
   localparam logic [4:0] NOP_RD = 5'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } st_e;

   // Number of bytes moved by a request, clamped to the data width.
   function automatic int size_bytes(input logic [1:0] size, input int nb);
      int n;
      case (size)
         SZ_B:    n = 1;
         SZ_H:    n = 2;
         SZ_W:    n = 4;
         default: n = nb;
      endcase
      return (n > nb) ? nb : n;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, writeback and byte-RAM signals of the access controller.
// master = pipeline/RAM environment, slave = the controller itself.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 17,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [4:0]        req_rd;
   logic              flush;
   logic              io_full;
   logic [RAM_AW-1:0] ram_a;
   logic              ram_wr;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic              resp_valid;
   logic              resp_we;
   logic [4:0]        resp_rd;
   logic [DATA_W-1:0] resp_data;
   logic              busy;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
             flush, io_full, ram_din,
      input  req_ready, ram_a, ram_wr, ram_dout, resp_valid, resp_we, resp_rd,
             resp_data, busy
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
             flush, io_full, ram_din,
      output req_ready, ram_a, ram_wr, ram_dout, resp_valid, resp_we, resp_rd,
             resp_data, busy
   );
endinterface

// File: rtl/mem_access_ctrl_ld_ext.sv
// Load-result extension: bytes above the transfer size are filled with the
// sign of the top transferred byte (signed loads) or with zero.
module mem_ld_ext
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   output logic [DATA_W-1:0] data_o
);
   localparam int NB = DATA_W / 8;

   int   n;
   logic fill;

   // Replace every byte beyond the transfer size with the fill byte
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional update, otherwise synthesis infers a latch.
      n      = size_bytes(size_i, NB);
      fill   = signed_i & data_i[8*n-1];
      data_o = data_i;
      for (int i = 0; i < NB; i++) begin
         if (i >= n) data_o[8*i +: 8] = {8{fill}};
      end
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// Serialises one load/store per transaction into byte accesses on a byte-wide
// RAM, reassembles loads little-endian and returns a registered writeback.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int RAM_AW  = 17,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1,
   parameter int IO_BIT  = IO_BIT_DEF
) (
   input logic              clk,
   input logic              rst,
   mem_access_ctrl_if.slave bus
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int CNT_W = IDX_W + 1;

   st_e               state_q, state_d;
   logic              we_q, sgn_q, io_q;
   logic [1:0]        size_q;
   logic [RAM_AW-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [4:0]        rd_q;
   logic [CNT_W-1:0]  n_q;
   logic [IDX_W-1:0]  k_q, k_d;
   logic [RAM_AW-1:0] ram_a_q, ram_a_d;
   logic [7:0]        dout_q, dout_d;
   logic [DATA_W-1:0] data_q, data_d, ext_data;
   logic [RAM_LAT-1:0] pv_q, pv_d;
   logic [IDX_W-1:0]  pidx_q [RAM_LAT];
   logic [IDX_W-1:0]  pidx_d [RAM_LAT];
   logic              resp_valid_d, resp_valid_q, resp_we_d, resp_we_q;
   logic [4:0]        resp_rd_d, resp_rd_q;
   logic [DATA_W-1:0] resp_data_d, resp_data_q;
   logic              accept, abort, last, wr_go, cap_now, cap_last;
   logic [IDX_W-1:0]  cap_idx;
   logic              addr_hi_unused;

   assign bus.req_ready = (state_q == ST_IDLE) && !bus.flush;
   assign accept        = bus.req_valid && bus.req_ready;
   assign abort         = !we_q && bus.flush && (state_q == ST_ISSUE || state_q == ST_WAIT);
   assign last          = ({1'b0, k_q} == n_q - 1'b1);
   assign wr_go         = (state_q == ST_ISSUE) && we_q && !(io_q && bus.io_full);
   assign cap_now       = pv_q[RAM_LAT-1];
   assign cap_idx       = pidx_q[RAM_LAT-1];
   assign cap_last      = cap_now && ({1'b0, cap_idx} == n_q - 1'b1);
   assign addr_hi_unused = ^bus.req_addr;

   assign bus.ram_wr     = wr_go;
   assign bus.ram_a      = ram_a_q;
   assign bus.ram_dout   = dout_q;
   assign bus.busy       = (state_q != ST_IDLE) || bus.req_valid;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_we    = resp_we_q;
   assign bus.resp_rd    = resp_rd_q;
   assign bus.resp_data  = resp_data_q;

   mem_ld_ext #(.DATA_W(DATA_W)) u_ext (
      .data_i   (data_d),
      .size_i   (size_q),
      .signed_i (sgn_q),
      .data_o   (ext_data)
   );

   // Next state, byte counter, RAM bus, capture pipe and response values
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ram_a_d = ram_a_q;
      dout_d  = dout_q;
      data_d  = data_q;
      pv_d[0]   = 1'b0;
      pidx_d[0] = k_q;
      for (int i = 1; i < RAM_LAT; i++) begin
         pv_d[i]   = pv_q[i-1];
         pidx_d[i] = pidx_q[i-1];
      end
      if (cap_now) data_d[8*int'(cap_idx) +: 8] = bus.ram_din;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ISSUE;
               k_d     = '0;
               ram_a_d = bus.req_addr[RAM_AW-1:0];
               dout_d  = bus.req_wdata[7:0];
               data_d  = '0;
            end
         end
         ST_ISSUE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (we_q) begin
               if (wr_go) begin
                  if (last) begin
                     state_d = ST_RESP;
                  end else begin
                     k_d     = k_q + 1'b1;
                     ram_a_d = addr_q + RAM_AW'(k_q) + RAM_AW'(1);
                     dout_d  = wdata_q[8*(int'(k_q)+1) +: 8];
                  end
               end
            end else begin
               pv_d[0] = 1'b1;
               if (io_q || last) begin
                  state_d = ST_WAIT;
               end else begin
                  k_d     = k_q + 1'b1;
                  ram_a_d = addr_q + RAM_AW'(k_q) + RAM_AW'(1);
               end
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cap_last) begin
               state_d = ST_RESP;
            end else if (io_q && cap_now) begin
               state_d = ST_ISSUE;
               k_d     = k_q + 1'b1;
               ram_a_d = addr_q + RAM_AW'(k_q) + RAM_AW'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (abort) pv_d = '0;

      resp_valid_d = (state_d == ST_RESP);
      resp_we_d    = resp_valid_d && !we_q && (rd_q != NOP_RD);
      resp_rd_d    = resp_valid_d ? rd_q : NOP_RD;
      resp_data_d  = (resp_valid_d && !we_q) ? ext_data : '0;
   end

   // FSM, counters, held bus values, assembled data and response registers
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         ram_a_q      <= '0;
         dout_q       <= '0;
         data_q       <= '0;
         pv_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_we_q    <= 1'b0;
         resp_rd_q    <= '0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         ram_a_q      <= ram_a_d;
         dout_q       <= dout_d;
         data_q       <= data_d;
         pv_q         <= pv_d;
         resp_valid_q <= resp_valid_d;
         resp_we_q    <= resp_we_d;
         resp_rd_q    <= resp_rd_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // Byte index travelling alongside each outstanding read
   always_ff @(posedge clk) begin
      // NOTE: no reset here; an index is only consumed when its valid bit in
      // pv_q is set, and those valid bits are reset.
      for (int i = 0; i < RAM_LAT; i++) pidx_q[i] <= pidx_d[i];
   end

   // Request fields latched on acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         io_q    <= 1'b0;
         size_q  <= SZ_B;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= NOP_RD;
         n_q     <= '0;
      end else if (accept) begin
         we_q    <= bus.req_we;
         sgn_q   <= bus.req_signed;
         io_q    <= bus.req_addr[IO_BIT];
         size_q  <= bus.req_size;
         addr_q  <= bus.req_addr[RAM_AW-1:0];
         wdata_q <= bus.req_wdata;
         rd_q    <= bus.req_rd;
         n_q     <= CNT_W'(size_bytes(bus.req_size, NB));
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: two controllers (read latency 1 and 3) with byte RAM models.
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        we;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   logic        pre_we = 1'b0;
   logic        pre_b = 1'b0;
   logic [16:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   logic [7:0]  mem_a [2**17];
   logic [7:0]  mem_b [2**17];
   logic [16:0] pa, pb0, pb1, pb2;
   logic        wr_seen;

   mem_access_ctrl_if #(.ADDR_W(32), .RAM_AW(17), .DATA_W(32)) a_if ();
   mem_access_ctrl_if #(.ADDR_W(32), .RAM_AW(17), .DATA_W(32)) b_if ();

   mem_access_ctrl #(.ADDR_W(32), .RAM_AW(17), .DATA_W(32), .RAM_LAT(1), .IO_BIT(17))
      dut_a (.clk(clk), .rst(rst), .bus(a_if));
   mem_access_ctrl #(.ADDR_W(32), .RAM_AW(17), .DATA_W(32), .RAM_LAT(3), .IO_BIT(17))
      dut_b (.clk(clk), .rst(rst), .bus(b_if));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte RAM models: latency 1 for A, 3 for B
   always @(posedge clk) begin
      pa <= a_if.ram_a;
      if (pre_we && !pre_b) mem_a[pre_addr] <= pre_data;
      else if (a_if.ram_wr) mem_a[a_if.ram_a] <= a_if.ram_dout;
   end
   always @(posedge clk) begin
      pb0 <= b_if.ram_a;
      pb1 <= pb0;
      pb2 <= pb1;
      if (pre_we && pre_b) mem_b[pre_addr] <= pre_data;
   end
   assign a_if.ram_din = mem_a[pa];
   assign b_if.ram_din = mem_b[pb2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response scoreboards
   always @(negedge clk) begin
      if (rst && a_if.resp_valid) begin
         if (qa.size() == 0) check("a_resp_unexpected", 1, 0);
         else begin
            ea = qa.pop_front();
            check("a_resp_data", a_if.resp_data, ea.data);
            check("a_resp_we", a_if.resp_we, ea.we);
            check("a_resp_rd", a_if.resp_rd, ea.rd);
            check("a_resp_cycle", cyc, ea.cyc);
         end
      end
      if (rst && b_if.resp_valid) begin
         if (qb.size() == 0) check("b_resp_unexpected", 1, 0);
         else begin
            eb = qb.pop_front();
            check("b_resp_data", b_if.resp_data, eb.data);
            check("b_resp_we", b_if.resp_we, eb.we);
            check("b_resp_rd", b_if.resp_rd, eb.rd);
            check("b_resp_cycle", cyc, eb.cyc);
         end
      end
   end

   task automatic preload(input logic sel_b, input logic [16:0] addr, input logic [7:0] d);
      pre_we = 1'b1; pre_b = sel_b; pre_addr = addr; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Present a request to A; lat>0 pushes the expected response at accept+lat
   task automatic issue_a(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] exp_data, input int lat);
      int   w = 0;
      exp_t e;
      a_if.req_valid = 1'b1; a_if.req_we = we; a_if.req_size = sz; a_if.req_signed = sgn;
      a_if.req_addr = addr; a_if.req_wdata = wd; a_if.req_rd = rd;
      @(negedge clk);
      while (!a_if.req_ready && w < 50) begin @(negedge clk); w++; end
      if (!a_if.req_ready) check("a_accept_timeout", 0, 1);
      else if (lat > 0) begin
         e.data = exp_data; e.we = !we && (rd != 5'd0); e.rd = rd; e.cyc = cyc + lat;
         qa.push_back(e);
      end
      @(posedge clk); #1;
      a_if.req_valid = 1'b0;
   endtask

   task automatic issue_b(input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] exp_data, input int lat);
      int   w = 0;
      exp_t e;
      b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_size = sz; b_if.req_signed = sgn;
      b_if.req_addr = addr; b_if.req_wdata = '0; b_if.req_rd = rd;
      @(negedge clk);
      while (!b_if.req_ready && w < 50) begin @(negedge clk); w++; end
      if (!b_if.req_ready) check("b_accept_timeout", 0, 1);
      else begin
         e.data = exp_data; e.we = (rd != 5'd0); e.rd = rd; e.cyc = cyc + lat;
         qb.push_back(e);
      end
      @(posedge clk); #1;
      b_if.req_valid = 1'b0;
   endtask

   // One cycle of RAM-port trace checking on A
   task automatic trace_a(input string tag, input logic [16:0] a, input logic wr, input logic [7:0] d);
      @(negedge clk);
      check({tag, "_ram_a"}, a_if.ram_a, a);
      check({tag, "_ram_wr"}, a_if.ram_wr, wr);
      if (wr) check({tag, "_ram_dout"}, a_if.ram_dout, d);
      @(posedge clk); #1;
   endtask

   task automatic drain(input logic sel_b);
      int t = 0;
      while (((sel_b ? qb.size() : qa.size()) != 0) && t < 60) begin @(posedge clk); #1; t++; end
      if (sel_b && qb.size() != 0) begin check("b_resp_timeout", qb.size(), 0); qb.delete(); end
      if (!sel_b && qa.size() != 0) begin check("a_resp_timeout", qa.size(), 0); qa.delete(); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_if.req_valid = 0; a_if.req_we = 0; a_if.req_size = 0; a_if.req_signed = 0;
      a_if.req_addr = 0; a_if.req_wdata = 0; a_if.req_rd = 0; a_if.flush = 0; a_if.io_full = 0;
      b_if.req_valid = 0; b_if.req_we = 0; b_if.req_size = 0; b_if.req_signed = 0;
      b_if.req_addr = 0; b_if.req_wdata = 0; b_if.req_rd = 0; b_if.flush = 0; b_if.io_full = 0;
      #1;
      check("rst_resp_valid", a_if.resp_valid, 0);
      check("rst_ram_wr", a_if.ram_wr, 0);
      check("rst_ram_a", a_if.ram_a, 0);
      check("rst_resp_data", a_if.resp_data, 0);
      check("rst_busy", a_if.busy, 0);
      check("rst_req_ready", a_if.req_ready, 1);

      // RAM contents used by the loads
      preload(0, 17'h100, 8'h78); preload(0, 17'h101, 8'h56);
      preload(0, 17'h102, 8'h34); preload(0, 17'h103, 8'h12);
      preload(0, 17'h20, 8'h80);
      preload(0, 17'h40, 8'hFF);  preload(0, 17'h41, 8'h7F);
      preload(0, 17'h50, 8'h00);  preload(0, 17'h51, 8'h80);
      for (int i = 0; i < 4; i++) preload(0, 17'h200 + 17'(i), 8'h55);
      preload(1, 17'h100, 8'h11); preload(1, 17'h101, 8'h22);
      preload(1, 17'h102, 8'h33); preload(1, 17'h103, 8'hC4);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Word load, latency 1: addresses in cycles 1-4, response in cycle 6
      issue_a(0, SZ_W, 1, 32'h100, 0, 5'd5, 32'h12345678, 6);
      for (int i = 0; i < 4; i++) trace_a("ld_w", 17'h100 + 17'(i), 1'b0, 8'h00);
      drain(0);

      // Extension cases and a write to the NOP register
      issue_a(0, SZ_B, 1, 32'h20, 0, 5'd1, 32'hFFFFFF80, 3); drain(0);
      issue_a(0, SZ_B, 0, 32'h20, 0, 5'd2, 32'h00000080, 3); drain(0);
      issue_a(0, SZ_H, 1, 32'h40, 0, 5'd3, 32'h00007FFF, 4); drain(0);
      issue_a(0, SZ_H, 1, 32'h50, 0, 5'd4, 32'hFFFF8000, 4); drain(0);
      issue_a(0, SZ_B, 1, 32'h20, 0, 5'd0, 32'hFFFFFF80, 3); drain(0);
      issue_a(0, 2'd3, 0, 32'h100, 0, 5'd6, 32'h12345678, 6); drain(0);

      // Half store wrapping the RAM address from all-ones to zero
      issue_a(1, SZ_H, 0, 32'h1FFFF, 32'h0000ABCD, 5'd7, 32'h0, 3);
      trace_a("st_wrap0", 17'h1FFFF, 1'b1, 8'hCD);
      trace_a("st_wrap1", 17'h00000, 1'b1, 8'hAB);
      drain(0);
      @(negedge clk);
      check("idle_ram_wr", a_if.ram_wr, 0);
      check("idle_ram_a_hold", a_if.ram_a, 17'h0);
      check("idle_ram_dout_hold", a_if.ram_dout, 8'hAB);
      check("mem_wrap_lo", mem_a[17'h1FFFF], 8'hCD);
      check("mem_wrap_hi", mem_a[17'h00000], 8'hAB);
      @(posedge clk); #1;

      // IO store held off by io_full for three cycles
      issue_a(1, SZ_B, 0, 32'h30000, 32'h41, 5'd9, 32'h0, 5);
      a_if.io_full = 1'b1;
      for (int i = 0; i < 3; i++) trace_a("io_full", 17'h10000, 1'b0, 8'h00);
      a_if.io_full = 1'b0;
      trace_a("io_go", 17'h10000, 1'b1, 8'h41);
      drain(0);

      // IO word load is strictly serial: 4*(1+1)+1 cycles
      issue_a(0, SZ_W, 0, 32'h20100, 0, 5'd10, 32'h12345678, 9); drain(0);

      // Flushed load: no response, ready again the cycle after the flush
      issue_a(0, SZ_W, 1, 32'h100, 0, 5'd11, 32'h0, 0);
      @(posedge clk); #1;
      a_if.flush = 1'b1;
      @(negedge clk);
      check("flush_ready_low", a_if.req_ready, 0);
      @(posedge clk); #1;
      a_if.flush = 1'b0;
      @(negedge clk);
      check("flush_ready_after", a_if.req_ready, 1);
      check("flush_busy_after", a_if.busy, 0);
      for (int i = 0; i < 6; i++) @(posedge clk);
      #1;
      a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_size = SZ_W;
      a_if.req_addr = 32'h77; a_if.req_rd = 5'd12; a_if.flush = 1'b1;
      @(negedge clk);
      check("flush_req_ready", a_if.req_ready, 0);
      check("flush_req_busy", a_if.busy, 1);
      @(posedge clk); #1;
      a_if.req_valid = 1'b0; a_if.flush = 1'b0;
      @(negedge clk);
      check("flush_not_accepted", a_if.busy, 0);
      check("flush_no_issue", a_if.ram_a == 17'h77, 0);
      @(posedge clk); #1;
      issue_a(0, SZ_W, 1, 32'h100, 0, 5'd13, 32'h12345678, 6); drain(0);

      // Reset in the middle of a word store, after its first byte is written
      issue_a(1, SZ_W, 0, 32'h200, 32'hDEADBEEF, 5'd0, 32'h0, 0);
      trace_a("rst_st0", 17'h200, 1'b1, 8'hEF);
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_ram_wr", a_if.ram_wr, 0);
      check("rst_async_resp", a_if.resp_valid, 0);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      wr_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (a_if.ram_wr || a_if.resp_valid) wr_seen = 1'b1;
      end
      check("rst_no_more_writes", wr_seen, 0);
      check("rst_idle_ready", a_if.req_ready, 1);
      check("rst_mem_b0", mem_a[17'h200], 8'hEF);
      check("rst_mem_b1", mem_a[17'h201], 8'h55);
      @(posedge clk); #1;

      // Latency-3 controller: word load and serial IO half load
      issue_b(SZ_W, 1, 32'h100, 5'd4, 32'hC4332211, 8); drain(1);
      issue_b(SZ_H, 0, 32'h20100, 5'd8, 32'h00002211, 9); drain(1);

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
